// File: rtl/axi_if.sv
// axi_if: AXI bus bundle (32-bit address/data, 4-bit id, 8-bit burst length)
// with a master view (drives requests) and a slave view (drives responses).
interface axi_if;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   modport master (
      output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_lite_xbar_router.sv
// axi_lite_xbar_router: 1-to-N AXI router; each transaction is decoded once from the
// address index slice, locked to one slave until its response, and unmapped targets get DECERR.
module axi_lite_xbar_router #(
   parameter int NUM_AXI_INTF = 2,
   parameter int SEL_MSB      = 31,
   parameter int SEL_WIDTH    = 4
) (
   input  logic  axi_aclk,
   input  logic  axi_aresetn,
   axi_if.slave  axi_s,
   axi_if.master axi_m [NUM_AXI_INTF]
);
   localparam int NS = 2**SEL_WIDTH;
   localparam logic [2:0] W_IDLE = 3'd0, W_ADDR = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3,
                          W_ERR_ADDR = 3'd4, W_ERR_DATA = 3'd5, W_ERR_RESP = 3'd6;
   localparam logic [2:0] R_IDLE = 3'd0, R_ADDR = 3'd1, R_DATA = 3'd2,
                          R_ERR_ADDR = 3'd3, R_ERR_DATA = 3'd4;
   logic [2:0]           ws, rs;
   logic [SEL_WIDTH-1:0] wsel, rsel, aw_idx, ar_idx;
   logic [3:0]           wid, rid;
   logic [7:0]           rlen, cnt;
   logic                 aw_map, ar_map;
   logic [NS-1:0]        awready_v, wready_v, bvalid_v, arready_v, rvalid_v, rlast_v;
   logic [1:0]           bresp_v [NS];
   logic [1:0]           rresp_v [NS];
   logic [3:0]           bid_v [NS];
   logic [3:0]           rid_v [NS];
   logic [31:0]          rdata_v [NS];
   assign aw_idx = axi_s.awaddr[SEL_MSB -: SEL_WIDTH];
   assign ar_idx = axi_s.araddr[SEL_MSB -: SEL_WIDTH];
   assign aw_map = {1'b0, aw_idx} < (SEL_WIDTH+1)'(NUM_AXI_INTF);
   assign ar_map = {1'b0, ar_idx} < (SEL_WIDTH+1)'(NUM_AXI_INTF);
   // Slots beyond the real slave count read as idle so the registered index can mux freely
   for (genvar i = 0; i < NS; i++) begin : g_slot
      if (i < NUM_AXI_INTF) begin : g_on
         logic aw_on, w_on, b_on, ar_on, r_on;
         assign aw_on = ws == W_ADDR && wsel == SEL_WIDTH'(i);
         assign w_on  = ws == W_DATA && wsel == SEL_WIDTH'(i);
         assign b_on  = ws == W_RESP && wsel == SEL_WIDTH'(i);
         assign ar_on = rs == R_ADDR && rsel == SEL_WIDTH'(i);
         assign r_on  = rs == R_DATA && rsel == SEL_WIDTH'(i);
         assign axi_m[i].awid    = aw_on ? axi_s.awid : 4'd0;
         assign axi_m[i].awaddr  = aw_on ? axi_s.awaddr : 32'd0;
         assign axi_m[i].awlen   = aw_on ? axi_s.awlen : 8'd0;
         assign axi_m[i].awvalid = aw_on && axi_s.awvalid;
         assign axi_m[i].wdata   = w_on ? axi_s.wdata : 32'd0;
         assign axi_m[i].wstrb   = w_on ? axi_s.wstrb : 4'd0;
         assign axi_m[i].wlast   = w_on && axi_s.wlast;
         assign axi_m[i].wvalid  = w_on && axi_s.wvalid;
         assign axi_m[i].bready  = b_on && axi_s.bready;
         assign axi_m[i].arid    = ar_on ? axi_s.arid : 4'd0;
         assign axi_m[i].araddr  = ar_on ? axi_s.araddr : 32'd0;
         assign axi_m[i].arlen   = ar_on ? axi_s.arlen : 8'd0;
         assign axi_m[i].arvalid = ar_on && axi_s.arvalid;
         assign axi_m[i].rready  = r_on && axi_s.rready;
         assign awready_v[i] = axi_m[i].awready;
         assign wready_v[i]  = axi_m[i].wready;
         assign bvalid_v[i]  = axi_m[i].bvalid;
         assign bresp_v[i]   = axi_m[i].bresp;
         assign bid_v[i]     = axi_m[i].bid;
         assign arready_v[i] = axi_m[i].arready;
         assign rvalid_v[i]  = axi_m[i].rvalid;
         assign rlast_v[i]   = axi_m[i].rlast;
         assign rresp_v[i]   = axi_m[i].rresp;
         assign rid_v[i]     = axi_m[i].rid;
         assign rdata_v[i]   = axi_m[i].rdata;
      end else begin : g_off
         assign awready_v[i] = 1'b0;
         assign wready_v[i]  = 1'b0;
         assign bvalid_v[i]  = 1'b0;
         assign bresp_v[i]   = 2'b00;
         assign bid_v[i]     = 4'd0;
         assign arready_v[i] = 1'b0;
         assign rvalid_v[i]  = 1'b0;
         assign rlast_v[i]   = 1'b0;
         assign rresp_v[i]   = 2'b00;
         assign rid_v[i]     = 4'd0;
         assign rdata_v[i]   = 32'd0;
      end
   end
   assign axi_s.awready = ws == W_ERR_ADDR || (ws == W_ADDR && awready_v[wsel]);
   assign axi_s.wready  = ws == W_ERR_DATA || (ws == W_DATA && wready_v[wsel]);
   assign axi_s.bvalid  = ws == W_ERR_RESP || (ws == W_RESP && bvalid_v[wsel]);
   assign axi_s.bresp   = ws == W_ERR_RESP ? 2'b11 : ws == W_RESP ? bresp_v[wsel] : 2'b00;
   assign axi_s.bid     = ws == W_ERR_RESP ? wid : ws == W_RESP ? bid_v[wsel] : 4'd0;
   assign axi_s.arready = rs == R_ERR_ADDR || (rs == R_ADDR && arready_v[rsel]);
   assign axi_s.rvalid  = rs == R_ERR_DATA || (rs == R_DATA && rvalid_v[rsel]);
   assign axi_s.rresp   = rs == R_ERR_DATA ? 2'b11 : rs == R_DATA ? rresp_v[rsel] : 2'b00;
   assign axi_s.rid     = rs == R_ERR_DATA ? rid : rs == R_DATA ? rid_v[rsel] : 4'd0;
   assign axi_s.rdata   = rs == R_DATA ? rdata_v[rsel] : 32'd0;
   assign axi_s.rlast   = rs == R_ERR_DATA ? cnt == rlen : rs == R_DATA && rlast_v[rsel];
   always_ff @(posedge axi_aclk or negedge axi_aresetn)
      if (!axi_aresetn) begin
         ws   <= W_IDLE;
         wsel <= '0;
         wid  <= '0;
      end else begin
         case (ws)
            W_IDLE: if (axi_s.awvalid) begin
               wsel <= aw_idx;
               wid  <= axi_s.awid;
               ws   <= aw_map ? W_ADDR : W_ERR_ADDR;
            end
            W_ADDR:     if (axi_s.awvalid && axi_s.awready) ws <= W_DATA;
            W_DATA:     if (axi_s.wvalid && axi_s.wready && axi_s.wlast) ws <= W_RESP;
            W_RESP:     if (axi_s.bvalid && axi_s.bready) ws <= W_IDLE;
            W_ERR_ADDR: ws <= W_ERR_DATA;
            W_ERR_DATA: if (axi_s.wvalid && axi_s.wlast) ws <= W_ERR_RESP;
            W_ERR_RESP: if (axi_s.bready) ws <= W_IDLE;
            default:    ws <= W_IDLE;
         endcase
      end
   always_ff @(posedge axi_aclk or negedge axi_aresetn)
      if (!axi_aresetn) begin
         rs   <= R_IDLE;
         rsel <= '0;
         rid  <= '0;
         rlen <= '0;
         cnt  <= '0;
      end else begin
         case (rs)
            R_IDLE: if (axi_s.arvalid) begin
               rsel <= ar_idx;
               rid  <= axi_s.arid;
               rlen <= axi_s.arlen;
               rs   <= ar_map ? R_ADDR : R_ERR_ADDR;
            end
            R_ADDR: if (axi_s.arvalid && axi_s.arready) rs <= R_DATA;
            R_DATA: if (axi_s.rvalid && axi_s.rready && axi_s.rlast) rs <= R_IDLE;
            R_ERR_ADDR: begin
               cnt <= '0;
               rs  <= R_ERR_DATA;
            end
            R_ERR_DATA: if (axi_s.rready) begin
               cnt <= cnt + 8'd1;
               if (cnt == rlen) rs <= R_IDLE;
            end
            default: rs <= R_IDLE;
         endcase
      end
endmodule

// File: tb/tb_axi_lite_xbar_router.sv
// tb_axi_lite_xbar_router: directed bench for the router with two zero-wait
// register slaves (16 words each, reset pattern A000_0000 | slave<<8 | word).
module tb_axi_lite_xbar_router;
   logic axi_aclk, axi_aresetn;
   axi_if s_if ();
   axi_if m_if [2] ();
   axi_lite_xbar_router #(.NUM_AXI_INTF(2), .SEL_MSB(31), .SEL_WIDTH(4)) dut (
      .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .axi_s(s_if), .axi_m(m_if));
   initial begin
      axi_aclk = 0;
      forever #5 axi_aclk = ~axi_aclk;
   end
   int tests = 0, fails = 0;
   logic [31:0] mem [2][16];
   int wact [2] = '{0, 0};
   int ract [2] = '{0, 0};
   logic [1:0] w_any, r_any;
   logic s_any;
   assign s_any = |{s_if.awready, s_if.wready, s_if.bvalid, s_if.bid, s_if.bresp, s_if.arready,
                    s_if.rvalid, s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast};
   for (genvar g = 0; g < 2; g++) begin : gs
      logic [3:0] wa, ra, bi, ri;
      logic [7:0] rl, rb;
      logic rbusy, bv;
      assign w_any[g] = |{m_if[g].awvalid, m_if[g].awaddr, m_if[g].awid, m_if[g].awlen, m_if[g].wvalid,
                          m_if[g].wdata, m_if[g].wstrb, m_if[g].wlast, m_if[g].bready};
      assign r_any[g] = |{m_if[g].arvalid, m_if[g].araddr, m_if[g].arid, m_if[g].arlen, m_if[g].rready};
      assign m_if[g].awready = 1'b1;
      assign m_if[g].wready  = 1'b1;
      assign m_if[g].bvalid  = bv;
      assign m_if[g].bid     = bi;
      assign m_if[g].bresp   = 2'b00;
      assign m_if[g].arready = !rbusy;
      assign m_if[g].rvalid  = rbusy;
      assign m_if[g].rid     = ri;
      assign m_if[g].rdata   = mem[g][ra];
      assign m_if[g].rresp   = 2'b00;
      assign m_if[g].rlast   = rbusy && rb == rl;
      always @(posedge axi_aclk) begin
         if (w_any[g]) wact[g] <= wact[g] + 1;
         if (r_any[g]) ract[g] <= ract[g] + 1;
      end
      always @(posedge axi_aclk or negedge axi_aresetn)
         if (!axi_aresetn) begin
            {wa, ra, bi, ri, rl, rb, rbusy, bv} <= '0;
            for (int k = 0; k < 16; k++) mem[g][k] <= 32'hA000_0000 | 32'(g * 256 + k);
         end else begin
            if (m_if[g].awvalid) begin
               wa <= m_if[g].awaddr[5:2];
               bi <= m_if[g].awid;
            end
            if (m_if[g].wvalid) begin
               mem[g][wa] <= m_if[g].wdata;
               wa <= wa + 4'd1;
               if (m_if[g].wlast) bv <= 1'b1;
            end
            if (bv && m_if[g].bready) bv <= 1'b0;
            if (!rbusy && m_if[g].arvalid) begin
               ra <= m_if[g].araddr[5:2];
               rl <= m_if[g].arlen;
               rb <= '0;
               ri <= m_if[g].arid;
               rbusy <= 1'b1;
            end else if (rbusy && m_if[g].rready) begin
               ra <= ra + 4'd1;
               rb <= rb + 8'd1;
               if (rb == rl) rbusy <= 1'b0;
            end
         end
   end
   logic [1:0] wr_resp;
   logic [3:0] wr_bid;
   logic wr_aw_after;
   int wr_aw_n, wr_cyc;
   logic [31:0] rd_data [8];
   logic [1:0] rd_resp [8];
   logic [3:0] rd_id [8];
   logic [7:0] rd_last;
   int rd_nb, rd_ar_n, rd_wait;
   task automatic clk1;
      @(posedge axi_aclk);
      #1;
   endtask
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] id,
                           input int beats, input bit chg);
      int n;
      bit to = 0;
      s_if.awaddr = addr;
      s_if.awid = id;
      s_if.awlen = 8'(beats - 1);
      s_if.awvalid = 1;
      n = 0;
      while (!s_if.awready && n < 20) begin clk1; n++; end
      to |= n >= 20;
      wr_aw_n = n;
      clk1;
      wr_cyc = n + 1;
      s_if.awvalid = 0;
      wr_aw_after = s_if.awready;
      if (chg) s_if.awaddr = 32'h0;
      for (int b = 0; b < beats; b++) begin
         s_if.wdata = data + 32'(b);
         s_if.wstrb = 4'hf;
         s_if.wlast = b == beats - 1;
         s_if.wvalid = 1;
         n = 0;
         while (!s_if.wready && n < 20) begin clk1; n++; end
         to |= n >= 20;
         clk1;
         wr_cyc += n + 1;
      end
      s_if.wvalid = 0;
      s_if.wlast = 0;
      s_if.bready = 1;
      n = 0;
      while (!s_if.bvalid && n < 20) begin clk1; n++; end
      to |= n >= 20;
      wr_resp = s_if.bresp;
      wr_bid = s_if.bid;
      clk1;
      wr_cyc += n + 1;
      s_if.bready = 0;
      tests++;
      if (to) begin fails++; $display("FAIL write_timeout addr %h: handshake never completed", addr); end
   endtask
   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
      int n;
      bit done = 0;
      s_if.araddr = addr;
      s_if.arlen = len;
      s_if.arid = id;
      s_if.arvalid = 1;
      n = 0;
      while (!s_if.arready && n < 20) begin clk1; n++; end
      rd_ar_n = n;
      clk1;
      s_if.arvalid = 0;
      s_if.rready = 1;
      rd_nb = 0;
      rd_wait = -1;
      rd_last = '0;
      n = 0;
      while (!done && n < 50) begin
         if (s_if.rvalid) begin
            if (rd_nb == 0) rd_wait = n;
            if (rd_nb < 8) begin
               rd_data[rd_nb] = s_if.rdata;
               rd_resp[rd_nb] = s_if.rresp;
               rd_id[rd_nb] = s_if.rid;
               rd_last[rd_nb] = s_if.rlast;
            end
            rd_nb++;
            done = s_if.rlast;
         end
         clk1;
         n++;
      end
      s_if.rready = 0;
      tests++;
      if (!done) begin fails++; $display("FAIL read_timeout addr %h: no rlast within 50 cycles", addr); end
   endtask
   task automatic test_reset;
      s_if.awaddr = 32'h1000_0000;
      s_if.awvalid = 1;
      s_if.araddr = 32'h1000_0000;
      s_if.arvalid = 1;
      s_if.wvalid = 1;
      s_if.bready = 1;
      s_if.rready = 1;
      repeat (3) clk1;
      tests++;
      if (s_any !== 1'b0) begin fails++; $display("FAIL reset_s_outputs: got %b want 0", s_any); end
      tests++;
      if (w_any !== 2'b00) begin fails++; $display("FAIL reset_m_write_outputs: got %b want 00", w_any); end
      tests++;
      if (r_any !== 2'b00) begin fails++; $display("FAIL reset_m_read_outputs: got %b want 00", r_any); end
      {s_if.awaddr, s_if.awvalid, s_if.araddr, s_if.arvalid, s_if.wvalid, s_if.bready, s_if.rready} = '0;
      @(negedge axi_aclk);
      axi_aresetn = 1;
      clk1;
   endtask
   task automatic test_write_mapped;
      int w0 = wact[0], w1 = wact[1];
      do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'd2, 1, 0);
      tests++;
      if (wr_resp !== 2'b00) begin fails++; $display("FAIL wr_bresp: got %b want 00", wr_resp); end
      tests++;
      if (wr_bid !== 4'd2) begin fails++; $display("FAIL wr_bid: got %0d want 2", wr_bid); end
      tests++;
      if (mem[1][1] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_mem1: got %h want deadbeef", mem[1][1]); end
      tests++;
      if (wact[0] != w0) begin fails++; $display("FAIL wr_leak_m0: got %0d active cycles want 0", wact[0] - w0); end
      tests++;
      if (wact[1] == w1) begin fails++; $display("FAIL wr_m1_active: got 0 active cycles want >0"); end
      tests++;
      if (wr_aw_n != 1) begin fails++; $display("FAIL wr_aw_latency: got %0d want 1", wr_aw_n); end
      tests++;
      if (wr_cyc != 4) begin fails++; $display("FAIL wr_total_cycles: got %0d want 4", wr_cyc); end
      tests++;
      if (wr_aw_after !== 1'b0) begin fails++; $display("FAIL wr_awready_after: got %b want 0", wr_aw_after); end
   endtask
   task automatic test_concurrent;
      int w0 = wact[0], r1 = ract[1];
      fork
         do_read(32'h0000_0010, 8'd0, 4'd1);
         do_write(32'h1000_0000, 32'h1234_5678, 4'd3, 1, 0);
      join
      tests++;
      if (rd_nb != 1 || rd_data[0] !== 32'hA000_0004 || rd_resp[0] !== 2'b00)
         begin fails++; $display("FAIL cc_read: got n=%0d data %h resp %b want n=1 a0000004 00", rd_nb, rd_data[0], rd_resp[0]); end
      tests++;
      if (rd_id[0] !== 4'd1) begin fails++; $display("FAIL cc_rid: got %0d want 1", rd_id[0]); end
      tests++;
      if (wr_resp !== 2'b00 || mem[1][0] !== 32'h1234_5678)
         begin fails++; $display("FAIL cc_write: got resp %b mem %h want 00 12345678", wr_resp, mem[1][0]); end
      tests++;
      if (wact[0] != w0 || ract[1] != r1)
         begin fails++; $display("FAIL cc_leak: got m0 write %0d m1 read %0d want 0 0", wact[0] - w0, ract[1] - r1); end
   endtask
   task automatic test_read_decerr;
      int r0 = ract[0] + ract[1];
      do_read(32'h3000_0000, 8'd3, 4'd6);
      tests++;
      if (rd_nb != 4) begin fails++; $display("FAIL rerr_beats: got %0d want 4", rd_nb); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if ({rd_data[k], rd_resp[k], rd_id[k]} !== {32'h0, 2'b11, 4'd6})
            begin fails++; $display("FAIL rerr_beat%0d: got data %h resp %b id %0d want 0 11 6", k, rd_data[k], rd_resp[k], rd_id[k]); end
      end
      tests++;
      if (rd_last !== 8'b0000_1000) begin fails++; $display("FAIL rerr_rlast: got %b want 00001000", rd_last); end
      tests++;
      if (ract[0] + ract[1] != r0) begin fails++; $display("FAIL rerr_leak: got %0d active cycles want 0", ract[0] + ract[1] - r0); end
      tests++;
      if (rd_ar_n != 1 || rd_wait != 0)
         begin fails++; $display("FAIL rerr_timing: got arready wait %0d rvalid wait %0d want 1 0", rd_ar_n, rd_wait); end
   endtask
   task automatic test_write_decerr;
      int w0 = wact[0] + wact[1];
      do_write(32'hF000_0000, 32'h1111_0000, 4'd5, 2, 0);
      tests++;
      if (wr_aw_n != 1 || wr_aw_after !== 1'b0)
         begin fails++; $display("FAIL werr_awready: got wait %0d after %b want 1 0", wr_aw_n, wr_aw_after); end
      tests++;
      if (wr_resp !== 2'b11 || wr_bid !== 4'd5)
         begin fails++; $display("FAIL werr_b: got resp %b bid %0d want 11 5", wr_resp, wr_bid); end
      tests++;
      if (wr_cyc != 5) begin fails++; $display("FAIL werr_cycles: got %0d want 5", wr_cyc); end
      tests++;
      if (wact[0] + wact[1] != w0) begin fails++; $display("FAIL werr_leak: got %0d active cycles want 0", wact[0] + wact[1] - w0); end
   endtask
   task automatic test_no_resteer;
      int w0 = wact[0];
      do_write(32'h1000_0008, 32'hCAFE_0001, 4'd1, 1, 1);
      tests++;
      if (mem[1][2] !== 32'hCAFE_0001 || wr_resp !== 2'b00)
         begin fails++; $display("FAIL resteer_m1: got mem %h resp %b want cafe0001 00", mem[1][2], wr_resp); end
      tests++;
      if (mem[0][0] !== 32'hA000_0000 || wact[0] != w0)
         begin fails++; $display("FAIL resteer_m0: got mem %h active %0d want a0000000 0", mem[0][0], wact[0] - w0); end
   endtask
   task automatic test_back_to_back;
      do_read(32'h1000_0004, 8'd0, 4'd7);
      tests++;
      if (rd_data[0] !== 32'hDEAD_BEEF || rd_id[0] !== 4'd7)
         begin fails++; $display("FAIL b2b_first: got %h id %0d want deadbeef 7", rd_data[0], rd_id[0]); end
      do_read(32'h0000_0014, 8'd0, 4'd8);
      tests++;
      if (rd_data[0] !== 32'hA000_0005 || rd_ar_n != 1)
         begin fails++; $display("FAIL b2b_second: got %h arwait %0d want a0000005 1", rd_data[0], rd_ar_n); end
   endtask
   task automatic test_reset_mid_read;
      int n = 0;
      s_if.araddr = 32'h0000_0000;
      s_if.arlen = 8'd0;
      s_if.arid = 4'd1;
      s_if.arvalid = 1;
      while (!s_if.arready && n < 20) begin clk1; n++; end
      clk1;
      s_if.arvalid = 0;
      clk1;
      tests++;
      if (s_if.rvalid !== 1'b1) begin fails++; $display("FAIL mid_rvalid_before: got %b want 1", s_if.rvalid); end
      s_if.rready = 1;
      s_if.arvalid = 1;
      #2 axi_aresetn = 0;
      #1;
      tests++;
      if (s_if.rvalid !== 1'b0 || s_if.arready !== 1'b0)
         begin fails++; $display("FAIL mid_reset_s: got rvalid %b arready %b want 0 0", s_if.rvalid, s_if.arready); end
      tests++;
      if (m_if[0].arvalid !== 1'b0 || m_if[0].rready !== 1'b0)
         begin fails++; $display("FAIL mid_reset_m0: got arvalid %b rready %b want 0 0", m_if[0].arvalid, m_if[0].rready); end
      @(negedge axi_aclk);
      s_if.rready = 0;
      s_if.arvalid = 0;
      @(negedge axi_aclk);
      axi_aresetn = 1;
      clk1;
      do_read(32'h0000_0000, 8'd0, 4'd2);
      tests++;
      if (rd_nb != 1 || rd_data[0] !== 32'hA000_0000 || rd_resp[0] !== 2'b00)
         begin fails++; $display("FAIL mid_after: got n=%0d data %h resp %b want n=1 a0000000 00", rd_nb, rd_data[0], rd_resp[0]); end
   endtask
   initial begin
      axi_aresetn = 0;
      {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awvalid, s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wvalid,
       s_if.bready, s_if.arid, s_if.araddr, s_if.arlen, s_if.arvalid, s_if.rready} = '0;
      test_reset;
      test_write_mapped;
      test_concurrent;
      test_read_decerr;
      test_write_decerr;
      test_no_resteer;
      test_back_to_back;
      test_reset_mid_read;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
